reg_scoreboard: RTL
===================

# reg_scoreboard

Producer-side hazard tracker for the five-stage MIPS pipeline. It records every in-flight instruction whose result will not reach the EX/MEM forwarding point in time, and holds the ID stage when a consumer or a same-destination writer would otherwise read a stale value. The forwarding logic covers every result already in EX/MEM or MEM/WB; this block covers the cycles before that, including load-use and multi-cycle multiply/divide. It sits beside the ID/EX pipeline register, and its `stall_o` drives the PC and IF/ID write enables.

## Interface
- `MAX_LAT`, default 7: largest latency an issue can request; `LAT_W = 3` bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `issue_valid_i`  in  1  ID stage holds a valid instruction.
- `issue_rs_i`  in  5  source register A.
- `issue_rt_i`  in  5  source register B.
- `issue_use_rt_i`  in  1  the instruction actually reads `rt`.
- `issue_rd_i`  in  5  destination register.
- `issue_regwrite_i`  in  1  the instruction writes `rd`.
- `issue_lat_i`  in  LAT_W  cycles until the result is forwardable. 0 for ALU ops, 1 for loads, N for multi-cycle ops.
- `flush_i`  in  1  the ID instruction is squashed this cycle (branch taken).
- `stall_o`  out  1  combinational; hold PC and IF/ID, insert a bubble into ID/EX.
- `issue_accept_o`  out  1  combinational; equals `issue_valid_i & ~stall_o & ~flush_i`.
- `busy_o`  out  32  registered; bit r is high while register r has a pending count.
- `inflight_o`  out  6  registered; number of busy registers.

## Operation
- **State.** One down-counter `cnt[r]` (LAT_W bits) per register r = 1..31. Register 0 has no counter; it is never busy and never stalls.
- **Busy.** `busy[r] = (cnt[r] != 0)`.
- **Stall condition.** `stall_o` is high when `issue_valid_i & ~flush_i` and any of the following holds:
  - (a) `busy[rs]`;
  - (b) `issue_use_rt_i & busy[rt]`;
  - (c) `issue_regwrite_i & rd != 0 & busy[rd]` (WAW protection).
- `stall_o` is evaluated from registered state only; it never depends on the decrement happening in the same cycle.
- **Per-edge update.** Every counter with `cnt != 0` decrements by 1. Then, if `issue_accept_o & issue_regwrite_i & rd != 0 & issue_lat_i != 0`, `cnt[rd] <= issue_lat_i`.
- Allocation cannot collide with a decrement: rule (c) guarantees the target counter is 0.
- `issue_lat_i == 0` allocates nothing; the forwarding path covers that result.
- `flush_i` suppresses both stall and allocation for that cycle. Counters already running are untouched, because they belong to older instructions that are not flushed.
- `inflight_o` is the population count of next-state busy bits, registered.
- **Reset.** All counters, `busy_o` and `inflight_o` go to 0. With `issue_valid_i` low, `stall_o` and `issue_accept_o` are 0.
- **Reset mid-operation.** Pending counts are dropped. The pipeline is flushed by the same reset.

## Timing
- An issue accepted in cycle t with latency L gives `busy[rd] = 1` in cycles t+1 through t+L and `busy[rd] = 0` from cycle t+L+1.
- A dependent instruction arriving in ID at cycle t+1 stalls for exactly L cycles and is accepted in cycle t+L+1.
- Load-use (L = 1) therefore costs one bubble.
- No cycles are added when `stall_o` is low.
- Maximum number of simultaneously pending registers is 31; `inflight_o` saturates naturally at 31.

## Structure
- Shared package `sb_pkg`: `NREG = 32`, `REG_W = 5`, `LAT_W = 3`, `MAX_LAT = 7`, and the named latency constants `LAT_ALU = 0`, `LAT_LOAD = 1`, `LAT_MUL = 3`, `LAT_DIV = 7`.
- One sub-module `sb_entry`: a single LAT_W down-counter with load port, load value and a `busy` output.
- `reg_scoreboard` instantiates 31 `sb_entry` instances via generate, plus the stall compare logic and the popcount.

## Test plan
- **Reset.** Hold `rst_i` for 2 cycles with random inputs. Then `busy_o = 0`, `inflight_o = 0`, and `stall_o = 0` when `issue_valid_i = 0`.
- **Load-use.** Load writing r8 with L = 1 accepted at t, then an `add` reading rs = r8 at t+1. `stall_o = 1` for 1 cycle only; the `add` is accepted at t+2; `busy_o[8]` is high in cycle t+1 only.
- **Multi-cycle.** `mul` to r10 with L = 3, then a consumer with rt = r10 and `issue_use_rt_i = 1`. Exactly 3 stall cycles follow. Repeating with `issue_use_rt_i = 0` gives 0 stall cycles.
- **WAW.** `div` to r5 with L = 7, then an ALU op writing r5 with L = 0. The ALU op stalls 7 cycles. `inflight_o` reads 1 for 7 cycles, then 0.
- **r0 and flush.**
  - Load with rd = r0 allocates nothing, and a later read of r0 never stalls.
  - Asserting `flush_i` during a stall drops `stall_o` to 0 and `issue_accept_o` to 0, and the counters keep decrementing.
- **Overlap.** Back-to-back `mul` r1 (L = 3), `mul` r2 (L = 3), and `add` reading r1 and r2. `inflight_o` goes 1, 2, 2, 1, 0. The `add` is accepted once `busy[r2]` clears, at issue cycle of the r2 `mul` + 4.

Source files
------------

// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared constants for the register scoreboard: register-file geometry,
// counter width, named producer latencies and a popcount helper.
// No ports.
// -----------------------------------------------------------------------------
package sb_pkg;

    localparam int NREG    = 32;
    localparam int REG_W   = 5;
    localparam int LAT_W   = 3;
    localparam int MAX_LAT = 7;

    // Cycles until a producer's result reaches the EX/MEM forwarding point.
    localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [LAT_W-1:0] LAT_MUL  = 3'd3;
    localparam logic [LAT_W-1:0] LAT_DIV  = 3'd7;

    // Number of set bits in a register-file-wide vector.
    function automatic logic [5:0] popcount32(input logic [NREG-1:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
// Issue-side bundle between the ID stage (master) and the scoreboard (slave).
//   issue_*      : decoded instruction currently in ID
//   flush_i      : ID instruction squashed this cycle
//   stall_o      : hold PC / IF/ID, bubble into ID/EX
//   issue_accept_o, busy_o, inflight_o : scoreboard status
// -----------------------------------------------------------------------------
interface reg_scoreboard_if;
    import sb_pkg::*;

    logic              issue_valid_i;
    logic [REG_W-1:0]  issue_rs_i;
    logic [REG_W-1:0]  issue_rt_i;
    logic              issue_use_rt_i;
    logic [REG_W-1:0]  issue_rd_i;
    logic              issue_regwrite_i;
    logic [LAT_W-1:0]  issue_lat_i;
    logic              flush_i;
    logic              stall_o;
    logic              issue_accept_o;
    logic [NREG-1:0]   busy_o;
    logic [5:0]        inflight_o;

    modport master (
        output issue_valid_i, issue_rs_i, issue_rt_i, issue_use_rt_i,
               issue_rd_i, issue_regwrite_i, issue_lat_i, flush_i,
        input  stall_o, issue_accept_o, busy_o, inflight_o
    );

    modport slave (
        input  issue_valid_i, issue_rs_i, issue_rt_i, issue_use_rt_i,
               issue_rd_i, issue_regwrite_i, issue_lat_i, flush_i,
        output stall_o, issue_accept_o, busy_o, inflight_o
    );

endinterface

// File: rtl/sb_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
// Pending-result down-counter for one architectural register.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : start a new count this edge
//   load_val_i     : cycles until the result is forwardable
//   busy_o         : current count is non-zero
//   busy_next_o    : count will be non-zero after this edge
// -----------------------------------------------------------------------------
module sb_entry
    import sb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             busy_next_o
);

    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] cnt_q;

    // Next count: a load only ever targets an idle counter, so it simply wins.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {LAT_W{1'b0}}) begin
            cnt_d = cnt_q - LAT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {LAT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o      = (cnt_q != {LAT_W{1'b0}});
    assign busy_next_o = (cnt_d != {LAT_W{1'b0}});

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Producer-side hazard tracker beside ID/EX. Each register r=1..31 has a
// down-counter holding the cycles left before its pending result becomes
// forwardable; ID is held while a source or the destination is still pending.
//   clk_i, rst_i : clock, synchronous active-high reset
//   sb           : issue bundle (slave side), see reg_scoreboard_if
// -----------------------------------------------------------------------------
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int MAX_LAT = 7
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    reg_scoreboard_if.slave  sb
);

    logic [NREG-1:0]  busy_s;
    logic [NREG-1:0]  busy_next_s;
    logic [NREG-1:0]  load_s;
    logic [LAT_W-1:0] lat_eff_s;
    logic             stall_s;
    logic             accept_s;
    logic             alloc_s;
    logic [5:0]       inflight_d;
    logic [5:0]       inflight_q;

    // r0 is hard-wired, so it never owns a counter and never reads as busy.
    assign busy_s[0]      = 1'b0;
    assign busy_next_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry u_entry (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_i      (load_s[r]),
            .load_val_i  (lat_eff_s),
            .busy_o      (busy_s[r]),
            .busy_next_o (busy_next_s[r])
        );
    end

    // Hazard check against registered busy bits only: RAW on rs/rt, WAW on rd.
    always_comb begin
        stall_s = 1'b0;
        if (sb.issue_valid_i && !sb.flush_i) begin
            stall_s = busy_s[sb.issue_rs_i]
                    | (sb.issue_use_rt_i & busy_s[sb.issue_rt_i])
                    | (sb.issue_regwrite_i & (sb.issue_rd_i != 5'd0) & busy_s[sb.issue_rd_i]);
        end else begin
            stall_s = 1'b0;
        end
    end

    assign accept_s = sb.issue_valid_i & ~stall_s & ~sb.flush_i;
    // Zero-latency results are covered by forwarding and need no tracking.
    assign alloc_s  = accept_s & sb.issue_regwrite_i & (sb.issue_rd_i != 5'd0)
                    & (sb.issue_lat_i != {LAT_W{1'b0}});

    // Clamp the requested latency to the configured ceiling.
    always_comb begin
        lat_eff_s = sb.issue_lat_i;
        if (int'(sb.issue_lat_i) > MAX_LAT) begin
            lat_eff_s = LAT_W'(MAX_LAT);
        end else begin
            lat_eff_s = sb.issue_lat_i;
        end
    end

    // One-hot load strobe toward the destination's counter.
    always_comb begin
        load_s = {NREG{1'b0}};
        if (alloc_s) begin
            load_s[sb.issue_rd_i] = 1'b1;
        end else begin
            load_s = {NREG{1'b0}};
        end
        load_s[0] = 1'b0;
    end

    assign inflight_d = popcount32(busy_next_s);

    // In-flight count register, aligned with the busy bits it summarises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 6'd0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign sb.stall_o        = stall_s;
    assign sb.issue_accept_o = accept_s;
    assign sb.busy_o         = busy_s;
    assign sb.inflight_o     = inflight_q;

endmodule
